// File: rtl/adc_spi_muestreo_pkg.sv
// Shared constants and helpers for the serial ADC acquisition stage.
// Frame layout and the offset-binary to two's-complement mapping live here.
package adc_spi_muestreo_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_QUIET    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 4;
    localparam int ADC_BITS   = 12;

    // Inverting the MSB of an offset-binary code yields the two's-complement code.
    function automatic logic signed [ADC_BITS-1:0] offset_to_tc(input logic [ADC_BITS-1:0] raw);
        return {~raw[ADC_BITS-1], raw[ADC_BITS-2:0]};
    endfunction

endpackage

// File: rtl/adc_spi_muestreo_contador_tick.sv
// Modulo-MODULO up-counter with enable and synchronous clear; tc flags the
// last count so the caller can use it as a periodic tick.
module contador_tick #(
    parameter int MODULO = 2000,
    parameter int CNT_W  = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [CNT_W-1:0] count_q, count_d;

    assign tc = (count_q == CNT_W'(MODULO - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/adc_spi_muestreo.sv
// Periodic sampler: clocks one 16-bit frame out of a serial ADC and presents
// the 12-bit sample as sign-extended two's complement with a one-cycle strobe.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   IDLE      | waiting for a sample tick
//   CS_SETUP  | cs_n low, sclk high, CLK_DIV cycles of setup
//   SHIFT     | 16 bit periods: sclk low then high, capture on rise
//   QUIET     | cs_n high, sclk high, CLK_DIV cycles
//   DONE      | dato updated, datolisto high for one cycle
module adc_spi_muestreo
    import adc_spi_muestreo_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 2000,
    parameter int OUT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sdata,
    output logic             sclk,
    output logic             cs_n,
    output logic [OUT_W-1:0] dato,
    output logic             datolisto,
    output logic             overrun
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    logic                tick;
    logic [2:0]          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [3:0]          bit_q, bit_d;
    logic                ph_q, ph_d;
    logic [ADC_BITS-1:0] sreg_q, sreg_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic [OUT_W-1:0]    dato_q, dato_d;
    logic                datolisto_q, datolisto_d;
    logic                overrun_q, overrun_d;
    logic signed [ADC_BITS-1:0] conv;

    contador_tick #(.MODULO(SAMPLE_PERIOD)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .clr   (~enable),
        .tc    (tick)
    );

    assign conv = offset_to_tc(sreg_q);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        sreg_d  = sreg_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_CS_SETUP;
                    div_d   = DIV_LOAD;
                end
            end
            ST_CS_SETUP: begin
                if (div_q == '0) begin
                    state_d = ST_SHIFT;
                    div_d   = DIV_LOAD;
                    ph_d    = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else begin
                    div_d = DIV_LOAD;
                    if (!ph_q) begin
                        // sclk rises on this edge: the ADC bit is stable now.
                        ph_d   = 1'b1;
                        sreg_d = {sreg_q[ADC_BITS-2:0], sdata};
                    end else if (bit_q == LAST_BIT) begin
                        state_d = ST_QUIET;
                    end else begin
                        ph_d  = 1'b0;
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_QUIET: begin
                if (div_q == '0) state_d = ST_DONE;
                else             div_d   = div_q - DIV_W'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered copies of what the next state dictates.
        cs_n_d      = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT));
        sclk_d      = !((state_d == ST_SHIFT) && !ph_d);
        datolisto_d = (state_d == ST_DONE);
        dato_d      = (state_d == ST_DONE) ? OUT_W'(conv) : dato_q;
        overrun_d   = overrun_q | (tick && (state_q != ST_IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            ph_q        <= 1'b1;
            sreg_q      <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            dato_q      <= '0;
            datolisto_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            ph_q        <= ph_d;
            sreg_q      <= sreg_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            dato_q      <= dato_d;
            datolisto_q <= datolisto_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign sclk      = sclk_q;
    assign dato      = dato_q;
    assign datolisto = datolisto_q;
    assign overrun   = overrun_q;

endmodule
